// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480@60 timing defaults and counter width
package vga_timing_pkg;
    localparam int CNT_W        = 10;
    localparam int CLK_DIV_DEF  = 2;

    localparam int H_SYNC_DEF   = 96;
    localparam int H_BACK_DEF   = 48;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FRONT_DEF  = 16;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BACK_DEF   = 33;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT_DEF  = 10;

    localparam int H_TOTAL_DEF     = H_SYNC_DEF + H_BACK_DEF + H_ACTIVE_DEF + H_FRONT_DEF;
    localparam int V_TOTAL_DEF     = V_SYNC_DEF + V_BACK_DEF + V_ACTIVE_DEF + V_FRONT_DEF;
    localparam int H_ACT_START_DEF = H_SYNC_DEF + H_BACK_DEF;
    localparam int V_ACT_START_DEF = V_SYNC_DEF + V_BACK_DEF;
endpackage

// File: rtl/VGAcomparator.sv
// rtl/VGAcomparator.sv - unsigned less-than compare used by the sync decode
module VGAcomparator #(
    parameter int W = 10
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         lt
);
    assign lt = (a < b);
endmodule

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - modulo-TOTAL position counter for one scan axis
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL = H_TOTAL_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
        end
    end

    assign count = r_count;
    assign wrap  = inc && (r_count == LAST);
endmodule

// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - VGA sequencer: pixel prescaler, h/v counters, sync and video decode
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = CLK_DIV_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BACK   = H_BACK_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FRONT  = H_FRONT_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BACK   = V_BACK_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FRONT  = V_FRONT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic             pix_tick,
    output logic [CNT_W-1:0] h_count,
    output logic [CNT_W-1:0] v_count,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [CNT_W-1:0] H_SYNC_V  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_V  = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_ACT_BEG = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_BEG = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [3:0]       DIV_LAST  = 4'(CLK_DIV - 1);

    logic [3:0] r_div_cnt;
    logic       w_h_wrap;
    logic       w_v_wrap;
    logic       w_h_lt;
    logic       w_v_lt;
    logic       w_h_act;
    logic       w_v_act;

    // Prescaler holds while en is low so a frozen raster resumes on the same phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt <= '0;
        end else if (en) begin
            r_div_cnt <= (r_div_cnt == DIV_LAST) ? 4'd0 : r_div_cnt + 4'd1;
        end
    end

    assign pix_tick = en && (r_div_cnt == DIV_LAST);

    vga_axis_counter #(.TOTAL(H_TOTAL)) u_h_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (pix_tick),
        .count (h_count),
        .wrap  (w_h_wrap)
    );

    vga_axis_counter #(.TOTAL(V_TOTAL)) u_v_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (w_h_wrap),
        .count (v_count),
        .wrap  (w_v_wrap)
    );

    assign line_start  = w_h_wrap;
    assign frame_start = w_v_wrap;

    VGAcomparator #(.W(CNT_W)) u_hsync_cmp (
        .a  (h_count),
        .b  (H_SYNC_V),
        .lt (w_h_lt)
    );

    VGAcomparator #(.W(CNT_W)) u_vsync_cmp (
        .a  (v_count),
        .b  (V_SYNC_V),
        .lt (w_v_lt)
    );

    assign hsync = ~w_h_lt;
    assign vsync = ~w_v_lt;

    assign w_h_act  = (h_count >= H_ACT_BEG) && (h_count < H_ACT_END);
    assign w_v_act  = (v_count >= V_ACT_BEG) && (v_count < V_ACT_END);
    assign video_on = w_h_act && w_v_act;

    assign x = video_on ? (h_count - H_ACT_BEG) : '0;
    assign y = video_on ? (v_count - V_ACT_BEG) : '0;
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb/tb_vga_timing_ctrl.sv - directed bench for vga_timing_ctrl (full-size and miniature rasters)
module tb_vga_timing_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       d_reset, d_en;
    logic       d_pix, d_hs, d_vs, d_vid, d_ls, d_fs;
    logic [9:0] d_h, d_v, d_x, d_y;

    logic       s_reset, s_en;
    logic       s_pix, s_hs, s_vs, s_vid, s_ls, s_fs;
    logic [9:0] s_h, s_v, s_x, s_y;

    vga_timing_ctrl dut (
        .clk(clk), .reset(d_reset), .en(d_en), .pix_tick(d_pix),
        .h_count(d_h), .v_count(d_v), .hsync(d_hs), .vsync(d_vs),
        .video_on(d_vid), .x(d_x), .y(d_y), .line_start(d_ls), .frame_start(d_fs)
    );

    // Miniature raster: H 2/2/4/2 (total 10), V 1/1/3/1 (total 6), one pixel per clk.
    vga_timing_ctrl #(
        .CLK_DIV(1), .H_SYNC(2), .H_BACK(2), .H_ACTIVE(4), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_ACTIVE(3), .V_FRONT(1)
    ) dut_s (
        .clk(clk), .reset(s_reset), .en(s_en), .pix_tick(s_pix),
        .h_count(s_h), .v_count(s_v), .hsync(s_hs), .vsync(s_vs),
        .video_on(s_vid), .x(s_x), .y(s_y), .line_start(s_ls), .frame_start(s_fs)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int th, input int tv);
        int n = 0;
        while (!(d_h == 10'(th) && d_v == 10'(tv)) && n < 70000) begin
            step();
            n++;
        end
        checks++;
        if (!(d_h == 10'(th) && d_v == 10'(tv))) begin
            errors++;
            $display("FAIL run_to timeout h=%0d v=%0d required h=%0d v=%0d", d_h, d_v, th, tv);
        end
    endtask

    task automatic test_reset();
        d_reset = 1'b1; d_en = 1'b0;
        step(); step();
        d_en = 1'b1;
        step();
        checks++; if (d_h !== 10'd0 || d_v !== 10'd0) begin errors++; $display("FAIL reset_counts h=%0d v=%0d required 0 0", d_h, d_v); end
        checks++; if (d_hs !== 1'b0 || d_vs !== 1'b0) begin errors++; $display("FAIL reset_sync hs=%b vs=%b required 0 0", d_hs, d_vs); end
        checks++; if (d_vid !== 1'b0 || d_x !== 10'd0 || d_y !== 10'd0) begin errors++; $display("FAIL reset_video vid=%b x=%0d y=%0d required 0 0 0", d_vid, d_x, d_y); end
        checks++; if (d_pix !== 1'b0 || d_ls !== 1'b0 || d_fs !== 1'b0) begin errors++; $display("FAIL reset_strobes pix=%b ls=%b fs=%b required 0 0 0", d_pix, d_ls, d_fs); end
        d_reset = 1'b0;
    endtask

    task automatic test_pix_tick();
        int ticks = 0;
        for (int i = 1; i <= 192; i++) begin
            step();
            if (d_pix === 1'b1) ticks++;
            if (i == 1) begin
                checks++; if (d_pix !== 1'b1) begin errors++; $display("FAIL first_tick pix=%b required 1", d_pix); end
            end
            if (i == 2) begin
                checks++; if (d_pix !== 1'b0) begin errors++; $display("FAIL tick_gap pix=%b required 0", d_pix); end
            end
            if (i == 191) begin
                checks++; if (d_h !== 10'd95 || d_hs !== 1'b0) begin errors++; $display("FAIL hsync_95 h=%0d hs=%b required 95 0", d_h, d_hs); end
            end
        end
        checks++; if (ticks != 96) begin errors++; $display("FAIL tick_count got %0d required 96", ticks); end
        checks++; if (d_h !== 10'd96 || d_hs !== 1'b1) begin errors++; $display("FAIL hsync_96 h=%0d hs=%b required 96 1", d_h, d_hs); end
    endtask

    task automatic test_line();
        int n = 0;
        int lines = 0;
        while (d_ls !== 1'b1 && n < 2000) begin step(); n++; end
        checks++; if (d_ls !== 1'b1 || d_h !== 10'd799 || d_pix !== 1'b1 || d_v !== 10'd0 || d_fs !== 1'b0) begin
            errors++; $display("FAIL line_start ls=%b h=%0d pix=%b v=%0d fs=%b required 1 799 1 0 0", d_ls, d_h, d_pix, d_v, d_fs);
        end
        step();
        checks++; if (d_h !== 10'd0 || d_v !== 10'd1 || d_ls !== 1'b0) begin errors++; $display("FAIL line_wrap h=%0d v=%0d ls=%b required 0 1 0", d_h, d_v, d_ls); end
        for (int i = 0; i < 1600; i++) begin
            step();
            if (d_ls === 1'b1) lines++;
        end
        checks++; if (lines != 1) begin errors++; $display("FAIL line_start_once got %0d required 1", lines); end
        checks++; if (d_h !== 10'd0 || d_v !== 10'd2) begin errors++; $display("FAIL second_line h=%0d v=%0d required 0 2", d_h, d_v); end
    endtask

    task automatic test_window();
        run_to(143, 35);
        checks++; if (d_vid !== 1'b0 || d_x !== 10'd0) begin errors++; $display("FAIL h143 vid=%b x=%0d required 0 0", d_vid, d_x); end
        run_to(144, 35);
        checks++; if (d_vid !== 1'b1 || d_x !== 10'd0 || d_y !== 10'd0 || d_vs !== 1'b1) begin errors++; $display("FAIL h144 vid=%b x=%0d y=%0d vs=%b required 1 0 0 1", d_vid, d_x, d_y, d_vs); end
        run_to(783, 35);
        checks++; if (d_vid !== 1'b1 || d_x !== 10'd639) begin errors++; $display("FAIL h783 vid=%b x=%0d required 1 639", d_vid, d_x); end
        run_to(784, 35);
        checks++; if (d_vid !== 1'b0 || d_x !== 10'd0) begin errors++; $display("FAIL h784 vid=%b x=%0d required 0 0", d_vid, d_x); end
    endtask

    task automatic test_freeze();
        run_to(300, 36);
        d_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (d_h !== 10'd300 || d_v !== 10'd36 || d_pix !== 1'b0 || d_ls !== 1'b0 || d_vid !== 1'b1 || d_x !== 10'd156 || d_y !== 10'd1 || d_hs !== 1'b1) begin
                errors++; $display("FAIL freeze h=%0d v=%0d pix=%b ls=%b vid=%b x=%0d y=%0d hs=%b required 300 36 0 0 1 156 1 1", d_h, d_v, d_pix, d_ls, d_vid, d_x, d_y, d_hs);
            end
        end
        d_en = 1'b1;
        step();
        checks++; if (d_h !== 10'd300 || d_pix !== 1'b1) begin errors++; $display("FAIL resume_tick h=%0d pix=%b required 300 1", d_h, d_pix); end
        step();
        checks++; if (d_h !== 10'd301 || d_pix !== 1'b0) begin errors++; $display("FAIL resume_advance h=%0d pix=%b required 301 0", d_h, d_pix); end
    endtask

    task automatic test_reset_mid();
        run_to(500, 36);
        d_reset = 1'b1;
        step();
        checks++; if (d_h !== 10'd0 || d_v !== 10'd0 || d_hs !== 1'b0 || d_vs !== 1'b0 || d_vid !== 1'b0 || d_pix !== 1'b0) begin
            errors++; $display("FAIL mid_reset h=%0d v=%0d hs=%b vs=%b vid=%b pix=%b required 0 0 0 0 0 0", d_h, d_v, d_hs, d_vs, d_vid, d_pix);
        end
        d_reset = 1'b0;
    endtask

    task automatic test_small_frames();
        int vs_low = 0, vid_cnt = 0, ls_cnt = 0, fs_cnt = 0;
        int fs_first = -1, fs_second = -1;
        int fh = -1, fv = -1, fx = -1, fy = -1, lh = -1, lv = -1, lx = -1, ly = -1;
        s_reset = 1'b1; s_en = 1'b0;
        step(); step();
        checks++; if (s_h !== 10'd0 || s_v !== 10'd0 || s_pix !== 1'b0 || s_hs !== 1'b0 || s_vs !== 1'b0) begin
            errors++; $display("FAIL small_reset h=%0d v=%0d pix=%b hs=%b vs=%b required 0 0 0 0 0", s_h, s_v, s_pix, s_hs, s_vs);
        end
        s_reset = 1'b0; s_en = 1'b1;
        #1;
        for (int i = 0; i < 130; i++) begin
            if (i < 5) begin
                checks++; if (s_pix !== 1'b1 || s_h !== 10'(i)) begin errors++; $display("FAIL div1_tick i=%0d pix=%b h=%0d required 1 %0d", i, s_pix, s_h, i); end
            end
            if (i < 60) begin
                if (s_vs === 1'b0) vs_low++;
                if (s_ls === 1'b1) ls_cnt++;
                if (s_vid === 1'b1) begin
                    vid_cnt++;
                    if (fh < 0) begin fh = int'(s_h); fv = int'(s_v); fx = int'(s_x); fy = int'(s_y); end
                    lh = int'(s_h); lv = int'(s_v); lx = int'(s_x); ly = int'(s_y);
                end
            end
            if (s_fs === 1'b1) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = i; else if (fs_second < 0) fs_second = i;
            end
            step();
        end
        checks++; if (fs_cnt != 2 || fs_first != 59) begin errors++; $display("FAIL frame_start count=%0d first=%0d required 2 59", fs_cnt, fs_first); end
        checks++; if (fs_second - fs_first != 60) begin errors++; $display("FAIL frame_period got %0d required 60", fs_second - fs_first); end
        checks++; if (vs_low != 10) begin errors++; $display("FAIL vsync_low got %0d required 10", vs_low); end
        checks++; if (vid_cnt != 12) begin errors++; $display("FAIL active_pixels got %0d required 12", vid_cnt); end
        checks++; if (ls_cnt != 6) begin errors++; $display("FAIL lines_per_frame got %0d required 6", ls_cnt); end
        checks++; if (fh != 4 || fv != 2 || fx != 0 || fy != 0) begin errors++; $display("FAIL first_active h=%0d v=%0d x=%0d y=%0d required 4 2 0 0", fh, fv, fx, fy); end
        checks++; if (lh != 7 || lv != 4 || lx != 3 || ly != 2) begin errors++; $display("FAIL last_active h=%0d v=%0d x=%0d y=%0d required 7 4 3 2", lh, lv, lx, ly); end
    endtask

    initial begin
        d_reset = 1'b1; d_en = 1'b0;
        s_reset = 1'b1; s_en = 1'b0;
        test_reset();
        test_pix_tick();
        test_line();
        test_window();
        test_freeze();
        test_reset_mid();
        test_small_frames();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
